// File: rtl/cam_centroid_fuse.sv
// Fuses per-camera centroid/proximity results into one selected target, with per-channel
// liveness watchdogs, selectable fusion mode and switching hysteresis.
module cam_centroid_fuse #(
  parameter int unsigned C_NCAM    = 2,
  parameter int unsigned C_NB_SEL  = 1,
  parameter int unsigned C_NB_CENT = 8,
  parameter int unsigned C_NB_PROX = 3,
  parameter int unsigned C_TIMEOUT = 2500000,
  parameter int unsigned C_NB_TOUT = 22,
  parameter int unsigned C_HYST    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [C_NCAM-1:0]             cam_valid,
  input  logic [C_NCAM*C_NB_CENT-1:0]   cam_centroid,
  input  logic [C_NCAM*C_NB_PROX-1:0]   cam_proximity,
  input  logic [1:0]                    mode,
  input  logic [C_NB_SEL-1:0]           sel_fixed,
  output logic                          out_valid,
  output logic [C_NB_SEL-1:0]           out_cam,
  output logic [C_NB_CENT-1:0]          out_centroid,
  output logic [C_NB_PROX-1:0]          out_proximity,
  output logic                          no_target,
  output logic [C_NCAM-1:0]             cam_alive
);

  localparam int unsigned NB_CMP = C_NB_PROX + 1;
  localparam logic [C_NB_SEL-1:0]  LAST_IDX  = C_NB_SEL'(C_NCAM - 1);
  localparam logic [C_NB_TOUT-1:0] TOUT_SAT  = C_NB_TOUT'(C_TIMEOUT);
  localparam logic [C_NB_TOUT-1:0] TOUT_LAST = C_NB_TOUT'(C_TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_OUT} state_e;

  state_e                state_q, state_d;
  logic [C_NB_SEL-1:0]   idx_q, idx_d;
  logic                  pending_q, pending_d;

  logic [C_NB_CENT-1:0]  ch_cent_q [C_NCAM];
  logic [C_NB_CENT-1:0]  ch_cent_d [C_NCAM];
  logic [C_NB_PROX-1:0]  ch_prox_q [C_NCAM];
  logic [C_NB_PROX-1:0]  ch_prox_d [C_NCAM];
  logic [C_NB_TOUT-1:0]  wdog_q    [C_NCAM];
  logic [C_NB_TOUT-1:0]  wdog_d    [C_NCAM];
  logic [C_NCAM-1:0]     alive_q, alive_d;
  logic                  event_c;

  // scan accumulators: max-prox candidate, current-camera status, round-robin successor
  logic [C_NB_SEL-1:0]   best_idx_q, best_idx_d, best_idx_n;
  logic [C_NB_PROX-1:0]  best_prox_q, best_prox_d, best_prox_n;
  logic                  best_ok_q, best_ok_d, best_ok_n;
  logic                  any_q, any_d, any_n;
  logic                  cur_ok_q, cur_ok_d, cur_ok_n;
  logic [C_NB_PROX-1:0]  cur_prox_q, cur_prox_d, cur_prox_n;
  logic                  aft_ok_q, aft_ok_d, aft_ok_n;
  logic [C_NB_SEL-1:0]   aft_idx_q, aft_idx_d, aft_idx_n;
  logic [C_NB_SEL-1:0]   first_idx_q, first_idx_d, first_idx_n;

  logic [C_NB_SEL-1:0]   sel_c;
  logic                  hold_c;
  logic                  keep_c;
  logic [C_NB_SEL-1:0]   fixed_c;

  logic                  out_valid_q, out_valid_d;
  logic [C_NB_SEL-1:0]   out_cam_q, out_cam_d;
  logic [C_NB_CENT-1:0]  out_centroid_q, out_centroid_d;
  logic [C_NB_PROX-1:0]  out_proximity_q, out_proximity_d;
  logic                  no_target_q, no_target_d;

  // channel latches and liveness watchdogs
  always_comb begin
    ch_cent_d = ch_cent_q;
    ch_prox_d = ch_prox_q;
    wdog_d    = wdog_q;
    alive_d   = alive_q;
    event_c   = |cam_valid;
    for (int unsigned i = 0; i < C_NCAM; i++) begin
      if (cam_valid[i]) begin
        ch_cent_d[i] = cam_centroid[i*C_NB_CENT +: C_NB_CENT];
        ch_prox_d[i] = cam_proximity[i*C_NB_PROX +: C_NB_PROX];
        alive_d[i]   = 1'b1;
        wdog_d[i]    = '0;
      end else begin
        if (wdog_q[i] != TOUT_SAT) wdog_d[i] = wdog_q[i] + C_NB_TOUT'(1);
        if (wdog_q[i] == TOUT_LAST && alive_q[i]) begin
          alive_d[i] = 1'b0;
          event_c    = 1'b1;
        end
      end
    end
  end

  // fold the channel visited this cycle into the accumulators (restart at idx 0)
  always_comb begin
    if (idx_q == '0) begin
      best_idx_n = '0;  best_prox_n = '0;  best_ok_n = 1'b0;  any_n = 1'b0;
      cur_ok_n   = 1'b0; cur_prox_n = '0;  aft_ok_n  = 1'b0;  aft_idx_n = '0;
      first_idx_n = '0;
    end else begin
      best_idx_n = best_idx_q; best_prox_n = best_prox_q; best_ok_n = best_ok_q;
      any_n      = any_q;      cur_ok_n    = cur_ok_q;    cur_prox_n = cur_prox_q;
      aft_ok_n   = aft_ok_q;   aft_idx_n   = aft_idx_q;   first_idx_n = first_idx_q;
    end
    if (alive_q[idx_q]) begin
      if (!best_ok_n || ch_prox_q[idx_q] > best_prox_n) begin
        best_idx_n  = idx_q;
        best_prox_n = ch_prox_q[idx_q];
        best_ok_n   = 1'b1;
      end
      if (!any_n) first_idx_n = idx_q;
      any_n = 1'b1;
      if (idx_q > out_cam_q && !aft_ok_n) begin
        aft_ok_n  = 1'b1;
        aft_idx_n = idx_q;
      end
    end
    if (idx_q == out_cam_q) begin
      cur_ok_n   = alive_q[idx_q];
      cur_prox_n = ch_prox_q[idx_q];
    end
  end

  // final selection, valid on the last scan cycle
  always_comb begin
    fixed_c = (32'(sel_fixed) >= C_NCAM) ? '0 : sel_fixed;
    keep_c  = cur_ok_n &&
              ({1'b0, best_prox_n} < ({1'b0, cur_prox_n} + NB_CMP'(C_HYST)));
    hold_c  = 1'b0;
    sel_c   = out_cam_q;
    case (mode)
      2'b00: sel_c = fixed_c;
      2'b10: begin
        hold_c = !any_n;
        sel_c  = aft_ok_n ? aft_idx_n : first_idx_n;
      end
      default: begin
        hold_c = !any_n;
        sel_c  = keep_c ? out_cam_q : best_idx_n;
      end
    endcase
    if (hold_c) sel_c = out_cam_q;
  end

  // control FSM: next state and registered outputs
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    pending_d       = pending_q;
    out_valid_d     = 1'b0;
    out_cam_d       = out_cam_q;
    out_centroid_d  = out_centroid_q;
    out_proximity_d = out_proximity_q;
    no_target_d     = no_target_q;
    best_idx_d  = best_idx_q;  best_prox_d = best_prox_q; best_ok_d = best_ok_q;
    any_d       = any_q;       cur_ok_d    = cur_ok_q;    cur_prox_d = cur_prox_q;
    aft_ok_d    = aft_ok_q;    aft_idx_d   = aft_idx_q;   first_idx_d = first_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (event_c) begin
          state_d   = ST_SCAN;
          idx_d     = '0;
          pending_d = 1'b0;
        end
      end
      ST_SCAN: begin
        best_idx_d  = best_idx_n;  best_prox_d = best_prox_n; best_ok_d = best_ok_n;
        any_d       = any_n;       cur_ok_d    = cur_ok_n;    cur_prox_d = cur_prox_n;
        aft_ok_d    = aft_ok_n;    aft_idx_d   = aft_idx_n;   first_idx_d = first_idx_n;
        if (event_c) pending_d = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d         = ST_OUT;
          out_valid_d     = 1'b1;
          out_cam_d       = sel_c;
          out_centroid_d  = hold_c ? out_centroid_q : ch_cent_q[sel_c];
          out_proximity_d = any_n ? ch_prox_q[sel_c] : '0;
          no_target_d     = !any_n;
        end else begin
          idx_d = idx_q + C_NB_SEL'(1);
        end
      end
      ST_OUT: begin
        pending_d = 1'b0;
        idx_d     = '0;
        state_d   = (pending_q || event_c) ? ST_SCAN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      idx_q           <= '0;
      pending_q       <= 1'b0;
      alive_q         <= '0;
      for (int unsigned i = 0; i < C_NCAM; i++) begin
        ch_cent_q[i] <= '0;
        ch_prox_q[i] <= '0;
        wdog_q[i]    <= '0;
      end
      best_idx_q  <= '0; best_prox_q <= '0; best_ok_q <= 1'b0; any_q <= 1'b0;
      cur_ok_q    <= 1'b0; cur_prox_q <= '0; aft_ok_q <= 1'b0; aft_idx_q <= '0;
      first_idx_q <= '0;
      out_valid_q     <= 1'b0;
      out_cam_q       <= '0;
      out_centroid_q  <= '0;
      out_proximity_q <= '0;
      no_target_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      pending_q       <= pending_d;
      alive_q         <= alive_d;
      ch_cent_q       <= ch_cent_d;
      ch_prox_q       <= ch_prox_d;
      wdog_q          <= wdog_d;
      best_idx_q  <= best_idx_d; best_prox_q <= best_prox_d; best_ok_q <= best_ok_d;
      any_q       <= any_d;      cur_ok_q    <= cur_ok_d;    cur_prox_q <= cur_prox_d;
      aft_ok_q    <= aft_ok_d;   aft_idx_q   <= aft_idx_d;   first_idx_q <= first_idx_d;
      out_valid_q     <= out_valid_d;
      out_cam_q       <= out_cam_d;
      out_centroid_q  <= out_centroid_d;
      out_proximity_q <= out_proximity_d;
      no_target_q     <= no_target_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_cam       = out_cam_q;
  assign out_centroid  = out_centroid_q;
  assign out_proximity = out_proximity_q;
  assign no_target     = no_target_q;
  assign cam_alive     = alive_q;

endmodule

// File: tb/tb_cam_centroid_fuse.sv
// Scoreboard bench for cam_centroid_fuse: directed scenarios plus randomized events,
// expectations from a fusion-rule reference model, compared by an independent monitor.
module tb_cam_centroid_fuse;
  localparam int N = 2;
  localparam int NB_SEL = 1;
  localparam int NB_CENT = 8;
  localparam int NB_PROX = 3;
  localparam int TOUT = 100;
  localparam int NB_TOUT = 8;
  localparam int HYST = 1;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [N-1:0]            cam_valid = '0;
  logic [N*NB_CENT-1:0]    cam_centroid = '0;
  logic [N*NB_PROX-1:0]    cam_proximity = '0;
  logic [1:0]              mode = 2'b01;
  logic [NB_SEL-1:0]       sel_fixed = '0;
  logic                    out_valid;
  logic [NB_SEL-1:0]       out_cam;
  logic [NB_CENT-1:0]      out_centroid;
  logic [NB_PROX-1:0]      out_proximity;
  logic                    no_target;
  logic [N-1:0]            cam_alive;

  cam_centroid_fuse #(
    .C_NCAM(N), .C_NB_SEL(NB_SEL), .C_NB_CENT(NB_CENT), .C_NB_PROX(NB_PROX),
    .C_TIMEOUT(TOUT), .C_NB_TOUT(NB_TOUT), .C_HYST(HYST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cam_valid(cam_valid), .cam_centroid(cam_centroid),
    .cam_proximity(cam_proximity), .mode(mode), .sel_fixed(sel_fixed),
    .out_valid(out_valid), .out_cam(out_cam), .out_centroid(out_centroid),
    .out_proximity(out_proximity), .no_target(no_target), .cam_alive(cam_alive)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int                 at;
    logic [NB_SEL-1:0]  cam;
    logic [NB_CENT-1:0] cent;
    logic [NB_PROX-1:0] prox;
    logic               nt;
    logic [N-1:0]       alive;
  } exp_t;

  exp_t sb[$];

  // reference model state
  logic [NB_CENT-1:0] m_cent [N];
  logic [NB_PROX-1:0] m_prox [N];
  bit                 m_alive[N];
  int                 m_last [N];
  int                 m_cur;
  logic [NB_CENT-1:0] m_cur_cent;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_cent[i] = '0; m_prox[i] = '0; m_alive[i] = 0; m_last[i] = 0;
    end
    m_cur = 0;
    m_cur_cent = '0;
  endfunction

  // selection from the fusion rules applied to the model's channel table
  function automatic exp_t predict(input int at);
    exp_t e;
    int n_alive = 0;
    int cam = m_cur;
    int best = -1;
    bit hold = 0;
    for (int i = 0; i < N; i++) if (m_alive[i]) n_alive++;
    case (mode)
      2'd0: cam = (int'(sel_fixed) >= N) ? 0 : int'(sel_fixed);
      2'd2: begin
        if (n_alive == 0) hold = 1;
        else begin
          for (int k = 1; k <= N; k++) begin
            if (m_alive[(m_cur + k) % N]) begin
              cam = (m_cur + k) % N;
              break;
            end
          end
        end
      end
      default: begin
        for (int j = 0; j < N; j++)
          if (m_alive[j] && (best < 0 || m_prox[j] > m_prox[best])) best = j;
        if (n_alive == 0) hold = 1;
        else if (m_alive[m_cur] && int'(m_prox[best]) < int'(m_prox[m_cur]) + HYST) cam = m_cur;
        else cam = best;
      end
    endcase
    e.at   = at;
    e.cam  = NB_SEL'(cam);
    e.cent = hold ? m_cur_cent : m_cent[cam];
    e.prox = (n_alive > 0) ? m_prox[cam] : '0;
    e.nt   = (n_alive == 0);
    for (int i = 0; i < N; i++) e.alive[i] = m_alive[i];
    m_cur = cam;
    m_cur_cent = e.cent;
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // monitor: every out_valid pulse is matched against the oldest expectation
  exp_t e_mon;
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid cyc=%0d cam=%0d", cyc, out_cam);
      end else begin
        e_mon = sb.pop_front();
        if (cyc != e_mon.at || out_cam !== e_mon.cam || out_centroid !== e_mon.cent ||
            out_proximity !== e_mon.prox || no_target !== e_mon.nt || cam_alive !== e_mon.alive) begin
          errors++;
          $display("FAIL out_pulse got cyc=%0d cam=%0d cent=%h prox=%0d nt=%0b alive=%b want cyc=%0d cam=%0d cent=%h prox=%0d nt=%0b alive=%b",
                   cyc, out_cam, out_centroid, out_proximity, no_target, cam_alive,
                   e_mon.at, e_mon.cam, e_mon.cent, e_mon.prox, e_mon.nt, e_mon.alive);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // drive one strobe cycle; lat > 0 queues the predicted output lat cycles later
  task automatic fire(input logic [N-1:0] m, input logic [7:0] c0, input logic [7:0] c1,
                      input logic [2:0] p0, input logic [2:0] p1, input int lat);
    int t = cyc;
    cam_valid     = m;
    cam_centroid  = {c1, c0};
    cam_proximity = {p1, p0};
    for (int i = 0; i < N; i++) begin
      if (m[i]) begin
        m_cent[i]  = (i == 0) ? c0 : c1;
        m_prox[i]  = (i == 0) ? p0 : p1;
        m_alive[i] = 1;
        m_last[i]  = t;
      end
    end
    if (lat > 0) sb.push_back(predict(t + lat));
    step(1);
    cam_valid = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cam_valid = '0;
    step(2);
    model_reset();
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 50; k++) begin
      if (sb.size() == 0) break;
      step(1);
    end
    chk(nm, sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    int t1;
    logic [N-1:0] m;
    model_reset();
    step(1);
    do_reset();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_cam", int'(out_cam), 0);
    chk("rst_out_centroid", int'(out_centroid), 0);
    chk("rst_out_proximity", int'(out_proximity), 0);
    chk("rst_no_target", int'(no_target), 0);
    chk("rst_cam_alive", int'(cam_alive), 0);

    // T1/T2: first target, then hysteresis hold and switch
    mode = 2'b01;
    fire(2'b01, 8'h40, 8'h00, 3'd3, 3'd0, 3);
    step(6);
    fire(2'b10, 8'h00, 8'h91, 3'd0, 3'd3, 3);
    step(6);
    fire(2'b10, 8'h00, 8'h92, 3'd0, 3'd4, 3);
    step(6);
    drain("t2_drain");

    // T3: simultaneous strobes then a mid-scan update collapse into one rescan
    do_reset();
    mode = 2'b01;
    fire(2'b11, 8'h11, 8'h22, 3'd2, 3'd6, 3);
    fire(2'b01, 8'h33, 8'h00, 3'd7, 3'd0, 5);
    step(10);
    drain("t3_drain");

    // T4: watchdog expiry of the selected camera, then of the last one
    do_reset();
    mode = 2'b01;
    t1 = cyc;
    fire(2'b10, 8'h00, 8'hA5, 3'd0, 3'd5, 3);
    step(9);
    t0 = cyc;
    fire(2'b01, 8'h5A, 8'h00, 3'd2, 3'd0, 3);
    m_alive[1] = 0;
    sb.push_back(predict(t1 + TOUT + 3));
    m_alive[0] = 0;
    sb.push_back(predict(t0 + TOUT + 3));
    step(t0 + TOUT + 8 - cyc);
    drain("t4_drain");
    chk("t4_no_target", int'(no_target), 1);
    chk("t4_cam_alive", int'(cam_alive), 0);

    // T5: round-robin rotation, then fixed selection
    do_reset();
    mode = 2'b10;
    for (int k = 0; k < 4; k++) begin
      fire(2'b11, 8'(8'h60 + k), 8'(8'h70 + k), 3'(k), 3'(k + 1), 3);
      step(6);
    end
    mode = 2'b00;
    sel_fixed = 1'b1;
    fire(2'b01, 8'h61, 8'h00, 3'd1, 3'd0, 3);
    step(6);
    drain("t5_drain");

    // randomized events, each isolated; alive channels refreshed before they expire
    do_reset();
    for (int n = 0; n < 150; n++) begin
      mode = 2'($urandom_range(0, 3));
      sel_fixed = NB_SEL'($urandom_range(0, 1));
      m = N'($urandom_range(1, 3));
      for (int i = 0; i < N; i++)
        if (m_alive[i] && (cyc - m_last[i]) > 60) m[i] = 1'b1;
      fire(m, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3);
      step($urandom_range(4, 8));
    end
    drain("rand_drain");

    // T6: reset in the middle of a scan
    mode = 2'b01;
    fire(2'b01, 8'hC3, 8'h00, 3'd5, 3'd0, 0);
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid", int'(out_valid), 0);
    chk("t6_out_cam", int'(out_cam), 0);
    chk("t6_out_centroid", int'(out_centroid), 0);
    chk("t6_out_proximity", int'(out_proximity), 0);
    chk("t6_no_target", int'(no_target), 0);
    chk("t6_cam_alive", int'(cam_alive), 0);
    step(2);
    model_reset();
    rst_n = 1'b1;
    step(10);
    chk("t6_alive_after", int'(cam_alive), 0);
    drain("final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
